// File: rtl/level_pkg.sv
// Shared level-sensor definitions used by the conditioner and the pump FSM.
package level_pkg;

  localparam int unsigned LEVEL_W  = 2;
  localparam int unsigned SENSOR_I = 0;
  localparam int unsigned SENSOR_S = 1;

  // Both pumps off, alternation held: the code the pump FSM treats as "stop".
  localparam logic [LEVEL_W-1:0] SAFE_LEVEL = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_OK      = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_FAULT   = 2'd3
  } level_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// One switch input: two-flop synchroniser followed by a saturating debounce counter.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic load,
  output logic debounced
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      debounced <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (load) begin
        debounced <= sync2;
        cnt       <= '0;
      end else if (sync2 != debounced) begin
        if (cnt >= CNT_LAST) begin
          debounced <= sync2;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/level_sensor_conditioner.sv
// Cleans the tank level switches for the pump FSM and latches implausible-code faults.
module level_sensor_conditioner
  import level_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FAULT_CYCLES    = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] raw_sensors,
  input  logic               fault_clear,
  output logic [LEVEL_W-1:0] level_sensors,
  output logic               level_valid,
  output logic               level_changed,
  output logic               sensor_fault
);

  localparam int unsigned INIT_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int unsigned FLT_W  = $clog2(FAULT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FAULT_CYCLES - 1);

  level_state_e       state;
  level_state_e       state_nxt;
  logic [INIT_W-1:0]  init_cnt;
  logic [INIT_W-1:0]  init_cnt_nxt;
  logic [FLT_W-1:0]   flt_cnt;
  logic [FLT_W-1:0]   flt_cnt_nxt;
  logic [LEVEL_W-1:0] deb;
  logic [LEVEL_W-1:0] level_prev;
  logic [LEVEL_W-1:0] level_c;
  logic               valid_c;
  logic               fault_c;
  logic               load_c;

  assign load_c = (state == ST_INIT);

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_i (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw_sensors[SENSOR_I]),
    .load      (load_c),
    .debounced (deb[SENSOR_I])
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw_sensors[SENSOR_S]),
    .load      (load_c),
    .debounced (deb[SENSOR_S])
  );

  // State, start-up counter and implausibility counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      flt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      flt_cnt  <= flt_cnt_nxt;
    end
  end

  // Next-state logic and the pre-register view of the outputs.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    flt_cnt_nxt  = flt_cnt;
    level_c      = SAFE_LEVEL;
    valid_c      = 1'b0;
    fault_c      = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt >= INIT_LAST) begin
          state_nxt    = ST_OK;
          init_cnt_nxt = '0;
        end else begin
          init_cnt_nxt = init_cnt + INIT_W'(1);
        end
      end
      ST_OK: begin
        level_c = deb;
        valid_c = 1'b1;
        if (deb == SAFE_LEVEL) begin
          state_nxt   = ST_SUSPECT;
          flt_cnt_nxt = FLT_W'(1);
        end
      end
      ST_SUSPECT: begin
        level_c = deb;
        valid_c = 1'b1;
        if (deb != SAFE_LEVEL) begin
          state_nxt   = ST_OK;
          flt_cnt_nxt = '0;
        end else if (flt_cnt >= FLT_LAST) begin
          state_nxt = ST_FAULT;
        end else begin
          flt_cnt_nxt = flt_cnt + FLT_W'(1);
        end
      end
      ST_FAULT: begin
        fault_c = 1'b1;
        if (fault_clear && (deb != SAFE_LEVEL)) begin
          state_nxt   = ST_OK;
          flt_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Registered outputs; level_changed flags the cycle after level_sensors moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_sensors <= SAFE_LEVEL;
      level_prev    <= SAFE_LEVEL;
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
      sensor_fault  <= 1'b0;
    end else begin
      level_sensors <= level_c;
      level_prev    <= level_sensors;
      level_valid   <= valid_c;
      level_changed <= (level_sensors != level_prev);
      sensor_fault  <= fault_c;
    end
  end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed and random checks of the level sensor conditioner against a cycle model.
module tb_level_sensor_conditioner;

  localparam int unsigned D = 16;
  localparam int unsigned F = 64;

  localparam int MD_INIT = 0;
  localparam int MD_OK   = 1;
  localparam int MD_SUSP = 2;
  localparam int MD_FLT  = 3;

  logic       clock;
  logic       reset;
  logic [1:0] raw_sensors;
  logic       fault_clear;
  logic [1:0] level_sensors;
  logic       level_valid;
  logic       level_changed;
  logic       sensor_fault;

  int errors = 0;
  int checks = 0;

  // Model state
  int         m_mode;
  int         m_init;
  int         m_bad;
  logic [1:0] m_deb;
  logic [1:0] m_lvl;
  logic [1:0] m_prev;
  logic       m_val;
  logic       m_chg;
  logic       m_flt;
  logic [1:0] raw_q[$];
  bit         hist[2][D];
  int         fill[2];

  level_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_sensors   (raw_sensors),
    .fault_clear   (fault_clear),
    .level_sensors (level_sensors),
    .level_valid   (level_valid),
    .level_changed (level_changed),
    .sensor_fault  (sensor_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one rising edge with the given inputs present.
  task automatic model_edge(input logic [1:0] r, input logic c, input logic rs);
    logic [1:0] sync;
    logic [1:0] o_lvl;
    logic       o_val;
    logic       o_flt;
    int         pre_mode;
    logic [1:0] pre_deb;
    bit         all_diff;
    if (rs) begin
      m_mode = MD_INIT; m_init = 0; m_bad = 0; m_deb = 2'b00;
      m_lvl = 2'b10; m_prev = 2'b10; m_val = 1'b0; m_chg = 1'b0; m_flt = 1'b0;
      raw_q.delete();
      fill[0] = 0; fill[1] = 0;
    end else begin
      pre_mode = m_mode;
      pre_deb  = m_deb;
      // raw sampled two edges ago reaches the debounce stage
      sync = (raw_q.size() >= 2) ? raw_q[$-1] : 2'b00;
      raw_q.push_back(r);
      if (raw_q.size() > 4) void'(raw_q.pop_front());
      // outputs reflect the state before this edge
      if (pre_mode == MD_OK || pre_mode == MD_SUSP) begin
        o_lvl = pre_deb; o_val = 1'b1; o_flt = 1'b0;
      end else begin
        o_lvl = 2'b10; o_val = 1'b0; o_flt = (pre_mode == MD_FLT);
      end
      m_chg  = (m_lvl != m_prev);
      m_prev = m_lvl;
      m_lvl  = o_lvl; m_val = o_val; m_flt = o_flt;
      // supervisory mode
      case (pre_mode)
        MD_INIT: begin
          m_init++;
          if (m_init == int'(D) + 2) m_mode = MD_OK;
        end
        MD_OK: if (pre_deb == 2'b10) begin m_mode = MD_SUSP; m_bad = 1; end
        MD_SUSP: begin
          if (pre_deb != 2'b10) m_mode = MD_OK;
          else begin
            m_bad++;
            if (m_bad >= int'(F)) m_mode = MD_FLT;
          end
        end
        default: if (c && pre_deb != 2'b10) m_mode = MD_OK;
      endcase
      // per-bit debounce: flip once the last D samples since the last flip all disagree
      for (int b = 0; b < 2; b++) begin
        if (pre_mode == MD_INIT) begin
          m_deb[b] = sync[b];
          fill[b]  = 0;
        end else begin
          for (int i = int'(D) - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
          hist[b][0] = sync[b];
          if (fill[b] < int'(D)) fill[b]++;
          if (fill[b] >= int'(D)) begin
            all_diff = 1'b1;
            for (int i = 0; i < int'(D); i++) if (hist[b][i] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) begin
              m_deb[b] = sync[b];
              fill[b]  = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic [1:0] r, input logic c, input logic rs);
    raw_sensors = r;
    fault_clear = c;
    reset       = rs;
    @(posedge clock);
    model_edge(r, c, rs);
    #1;
    chk("model_level", 8'(level_sensors), 8'(m_lvl));
    chk("model_valid", 8'(level_valid), 8'(m_val));
    chk("model_changed", 8'(level_changed), 8'(m_chg));
    chk("model_fault", 8'(sensor_fault), 8'(m_flt));
  endtask

  initial begin
    logic       saw10;
    logic [1:0] r;
    int         len;
    raw_sensors = 2'b01;
    fault_clear = 1'b0;
    reset       = 1'b1;
    fill[0] = 0; fill[1] = 0;

    // Start-up with raw=01
    tick(2'b01, 1'b0, 1'b1);
    chk("reset_level", 8'(level_sensors), 8'h2);
    chk("reset_valid", 8'(level_valid), 8'h0);
    chk("reset_fault", 8'(sensor_fault), 8'h0);
    for (int j = 0; j < 18; j++) begin
      tick(2'b01, 1'b0, 1'b0);
      chk("start_safe", 8'(level_sensors), 8'h2);
      chk("start_invalid", 8'(level_valid), 8'h0);
    end
    tick(2'b01, 1'b0, 1'b0);
    chk("start_level", 8'(level_sensors), 8'h1);
    chk("start_valid", 8'(level_valid), 8'h1);
    chk("start_nochg", 8'(level_changed), 8'h0);
    tick(2'b01, 1'b0, 1'b0);
    chk("start_chg", 8'(level_changed), 8'h1);
    tick(2'b01, 1'b0, 1'b0);
    chk("start_chg_end", 8'(level_changed), 8'h0);

    // Short glitch must not propagate
    for (int j = 0; j < 10; j++) tick(2'b00, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) begin
      tick(2'b01, 1'b0, 1'b0);
      chk("glitch_hold", 8'(level_sensors), 8'h1);
    end
    // Held change lands 18 edges later, one-cycle changed pulse after that
    for (int j = 0; j < 23; j++) begin
      tick(2'b00, 1'b0, 1'b0);
      chk("deb_level", 8'(level_sensors), (j >= 18) ? 8'h0 : 8'h1);
      chk("deb_chg", 8'(level_changed), (j == 19) ? 8'h1 : 8'h0);
    end

    // Transient implausible code passes through without a fault
    saw10 = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick(2'b10, 1'b0, 1'b0);
      if (level_sensors == 2'b10 && level_valid) saw10 = 1'b1;
      chk("trans_nofault", 8'(sensor_fault), 8'h0);
    end
    for (int j = 0; j < 40; j++) begin
      tick(2'b11, 1'b0, 1'b0);
      chk("trans_nofault2", 8'(sensor_fault), 8'h0);
    end
    chk("trans_passed10", 8'(saw10), 8'h1);
    chk("trans_final", 8'(level_sensors), 8'h3);

    // Persistent 10: debounced at +17, fault state at +81, registered at +82
    for (int j = 0; j < 86; j++) begin
      tick(2'b10, 1'b0, 1'b0);
      chk("fault_time", 8'(sensor_fault), (j >= 82) ? 8'h1 : 8'h0);
    end
    chk("fault_level", 8'(level_sensors), 8'h2);
    chk("fault_valid", 8'(level_valid), 8'h0);
    for (int j = 0; j < 30; j++) tick(2'b01, 1'b0, 1'b0);
    chk("fault_held", 8'(sensor_fault), 8'h1);
    chk("fault_held_lvl", 8'(level_sensors), 8'h2);
    tick(2'b01, 1'b1, 1'b0);
    chk("clear_edge", 8'(sensor_fault), 8'h1);
    tick(2'b01, 1'b0, 1'b0);
    chk("clear_level", 8'(level_sensors), 8'h1);
    chk("clear_valid", 8'(level_valid), 8'h1);
    chk("clear_fault", 8'(sensor_fault), 8'h0);

    // Clear ignored while the code still reads 10
    for (int j = 0; j < 100; j++) tick(2'b10, 1'b0, 1'b0);
    chk("ign_faulted", 8'(sensor_fault), 8'h1);
    tick(2'b10, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(2'b10, 1'b0, 1'b0);
      chk("ign_fault", 8'(sensor_fault), 8'h1);
      chk("ign_level", 8'(level_sensors), 8'h2);
    end

    // Reset while faulted
    tick(2'b10, 1'b0, 1'b1);
    chk("rst_fault", 8'(sensor_fault), 8'h0);
    chk("rst_level", 8'(level_sensors), 8'h2);
    chk("rst_valid", 8'(level_valid), 8'h0);
    for (int j = 0; j < 18; j++) begin
      tick(2'b10, 1'b0, 1'b0);
      chk("rst_init", 8'(level_valid), 8'h0);
    end
    tick(2'b10, 1'b0, 1'b0);
    chk("rst_ok", 8'(level_valid), 8'h1);

    // Random segments against the model
    for (int seg = 0; seg < 60; seg++) begin
      r   = 2'($urandom_range(0, 3));
      len = (r == 2'b10) ? int'($urandom_range(1, 110)) : int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin
        tick(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
